cp_remover: RTL



---
 rtl/cp_remover_if.sv | 39 +++
 rtl/cp_remover.sv | 135 +++++++++++++
 2 files changed

// File: rtl/cp_remover_if.sv
// Sample-stream bundle between timing sync (master) and the CP remover (slave).
// The err/err_cnt pair exists only when CP_REMOVER_ERR_EN is defined.
interface cp_remover_if #(
  parameter int SYM_W = 8
);
  logic signed [11:0] di_re;
  logic signed [11:0] di_im;
  logic               di_vld;
  logic               sym_start;
  logic [SYM_W-1:0]   n_sym;
  logic signed [11:0] do_re;
  logic signed [11:0] do_im;
  logic               do_vld;
  logic               do_last;
  logic [SYM_W-1:0]   sym_idx;
  logic               busy;
`ifdef CP_REMOVER_ERR_EN
  logic               err;
  logic [7:0]         err_cnt;

  modport master (
    output di_re, di_im, di_vld, sym_start, n_sym,
    input  do_re, do_im, do_vld, do_last, sym_idx, busy, err, err_cnt
  );
  modport slave (
    input  di_re, di_im, di_vld, sym_start, n_sym,
    output do_re, do_im, do_vld, do_last, sym_idx, busy, err, err_cnt
  );
`else
  modport master (
    output di_re, di_im, di_vld, sym_start, n_sym,
    input  do_re, do_im, do_vld, do_last, sym_idx, busy
  );
  modport slave (
    input  di_re, di_im, di_vld, sym_start, n_sym,
    output do_re, do_im, do_vld, do_last, sym_idx, busy
  );
`endif
endinterface

// File: rtl/cp_remover.sv
// Cyclic-prefix remover: forwards the N-sample FFT window of every OFDM symbol,
// advanced BACKOFF samples into the prefix. Define CP_REMOVER_ERR_EN for err/err_cnt.
module cp_remover #(
  parameter int N       = 64,
  parameter int CP      = 16,
  parameter int BACKOFF = 2,
  parameter int SYM_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  cp_remover_if.slave bus
);

  localparam int CW = $clog2(CP + N + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SKIP_HEAD = 2'd1;
  localparam logic [1:0] PASS      = 2'd2;
  localparam logic [1:0] SKIP_TAIL = 2'd3;

  localparam logic [CW-1:0] HEAD_C = CW'(CP - BACKOFF);
  localparam logic [CW-1:0] WEND_C = CW'(CP - BACKOFF + N);
  localparam logic [CW-1:0] LAST_C = CW'(CP - BACKOFF + N - 1);
  localparam logic [CW-1:0] TOT_C  = CW'(CP + N - 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SYM_W-1:0]   sym_q, sym_d;
  logic [SYM_W-1:0]   nsym_q, nsym_d;
  logic signed [11:0] do_re_q, do_im_q;
  logic               do_vld_q, do_last_q;
  logic [SYM_W-1:0]   sym_out_q;

  logic               restart, take, fwd, last;
  logic [CW-1:0]      idx, nxt;
  logic [SYM_W-1:0]   sym_cur, nsym_cur, sym_inc;

  // State that owns the sample at in-symbol index i.
  function automatic logic [1:0] phase(input logic [CW-1:0] i);
    if (i < HEAD_C)      return SKIP_HEAD;
    else if (i < WEND_C) return PASS;
    else                 return SKIP_TAIL;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sym_d    = sym_q;
    nsym_d   = nsym_q;
    // A start pulse inside the window is ignored so the FFT framing never breaks.
    restart  = bus.di_vld && bus.sym_start && (state_q != PASS);
    take     = bus.di_vld && (restart || (state_q != IDLE));
    idx      = restart ? '0 : cnt_q;
    sym_cur  = restart ? '0 : sym_q;
    nsym_cur = restart ? bus.n_sym : nsym_q;
    nxt      = idx + 1'b1;
    sym_inc  = SYM_W'(sym_cur + 1'b1);
    fwd      = take && (idx >= HEAD_C) && (idx < WEND_C);
    last     = fwd && (idx == LAST_C);
    if (take) begin
      nsym_d = nsym_cur;
      if (idx == TOT_C) begin
        cnt_d = '0;
        if ((nsym_cur != '0) && (sym_inc == nsym_cur)) begin
          state_d = IDLE;
          sym_d   = '0;
        end else begin
          state_d = phase('0);
          sym_d   = sym_inc;
        end
      end else begin
        cnt_d   = nxt;
        sym_d   = sym_cur;
        state_d = phase(nxt);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sym_q     <= '0;
      nsym_q    <= '0;
      do_re_q   <= '0;
      do_im_q   <= '0;
      do_vld_q  <= 1'b0;
      do_last_q <= 1'b0;
      sym_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sym_q     <= sym_d;
      nsym_q    <= nsym_d;
      do_vld_q  <= fwd;
      do_last_q <= last;
      if (fwd) begin
        do_re_q   <= bus.di_re;
        do_im_q   <= bus.di_im;
        sym_out_q <= sym_cur;
      end else if (state_d == IDLE) begin
        sym_out_q <= '0;
      end
    end
  end

  assign bus.do_re   = do_re_q;
  assign bus.do_im   = do_im_q;
  assign bus.do_vld  = do_vld_q;
  assign bus.do_last = do_last_q;
  assign bus.sym_idx = sym_out_q;
  assign bus.busy    = (state_q != IDLE);

`ifdef CP_REMOVER_ERR_EN
  logic       err_q;
  logic [7:0] err_cnt_q;
  logic       ignored;

  assign ignored = bus.di_vld && bus.sym_start && (state_q == PASS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= ignored;
      if (ignored && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;
`endif

endmodule
